// File: rtl/sync_frame_tx.sv
// sync_frame_tx: serialises one payload word per frame onto w as 1,1,0,1 sync, payload MSB first, optional parity.
// Ports:
//   Clock      - single clock, rising edge
//   Reset      - synchronous active-low reset
//   data_in    - payload word, captured on acceptance
//   data_valid - producer offers data_in
//   data_ready - registered, high only in IDLE after reset release
//   w          - registered serial line, idles at 0
//   busy       - registered, high while w carries frame bits
//   done       - registered, pulses with the last frame bit
// Build option: define SYNC_FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module sync_frame_tx #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [PAYLOAD_W-1:0] data_in,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 w,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = $clog2(PAYLOAD_W + 1);
    localparam logic [CW-1:0] LAST = CW'(PAYLOAD_W - 1);
    typedef enum logic [1:0] {
        IDLE,
        SYNC,
`ifdef SYNC_FRAME_TX_PARITY_EN
        DATA,
        PARITY
`else
        DATA
`endif
    } state_t;
    state_t               state, state_n;
    logic [1:0]           sync_cnt, sync_cnt_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [PAYLOAD_W-1:0] sr, sr_n;
    logic                 w_n, busy_n, done_n, ready_n;
    logic                 accept;
`ifdef SYNC_FRAME_TX_PARITY_EN
    logic                 par, par_n;
`endif
    // data_ready is registered, so the first IDLE cycle after reset cannot accept
    assign accept = (state == IDLE) && data_ready && data_valid;
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= IDLE;
            sync_cnt   <= '0;
            cnt        <= '0;
            sr         <= '0;
            w          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_ready <= 1'b0;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sync_cnt   <= sync_cnt_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            w          <= w_n;
            busy       <= busy_n;
            done       <= done_n;
            data_ready <= ready_n;
`ifdef SYNC_FRAME_TX_PARITY_EN
            par        <= par_n;
`endif
        end
    end
    always_comb begin
        state_n    = state;
        sync_cnt_n = sync_cnt;
        cnt_n      = cnt;
        sr_n       = sr;
`ifdef SYNC_FRAME_TX_PARITY_EN
        par_n      = accept ? ^data_in : par;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = SYNC;
                    sync_cnt_n = '0;
                    cnt_n      = '0;
                    sr_n       = data_in;
                end
            end
            SYNC: begin
                sync_cnt_n = sync_cnt + 2'd1;
                state_n    = (sync_cnt == 2'd3) ? DATA : SYNC;
            end
            DATA: begin
                // shifting as each bit leaves keeps the next bit at the MSB
                sr_n  = sr << 1;
                cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
`ifdef SYNC_FRAME_TX_PARITY_EN
                state_n = (cnt == LAST) ? PARITY : DATA;
`else
                state_n = (cnt == LAST) ? IDLE : DATA;
`endif
            end
`ifdef SYNC_FRAME_TX_PARITY_EN
            PARITY: state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end
    // outputs are derived from the upcoming state so they can be registered without lag
    always_comb begin
        busy_n  = state_n != IDLE;
        ready_n = state_n == IDLE;
`ifdef SYNC_FRAME_TX_PARITY_EN
        w_n    = (state_n == SYNC) ? (sync_cnt_n != 2'd2) :
                 (state_n == DATA) ? sr_n[PAYLOAD_W-1] :
                 (state_n == PARITY) && par_n;
        done_n = state_n == PARITY;
`else
        w_n    = (state_n == SYNC) ? (sync_cnt_n != 2'd2) :
                 (state_n == DATA) && sr_n[PAYLOAD_W-1];
        done_n = (state_n == DATA) && (cnt_n == LAST);
`endif
    end
endmodule

// File: doc/sync_frame_tx.md
SYNC_FRAME_TX -- requirements
Module: sync_frame_tx

Interface
REQ-001 SHALL have parameter: PAYLOAD_W, 8, payload bits per frame (legal range 1..32).
REQ-002 SHALL have port: Clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-low reset; sampled on rising Clock edge only.
REQ-004 SHALL have port: data_in  input  PAYLOAD_W  payload word; captured on acceptance.
REQ-005 SHALL have port: data_valid  input  1  producer offers data_in.
REQ-006 SHALL have port: data_ready  output  1  registered; block accepts a word this cycle.
REQ-007 SHALL have port: w  output  1  registered serial line to the sync detector; idles at 0.
REQ-008 SHALL have port: busy  output  1  registered; high while a frame is on w.
REQ-009 SHALL have port: done  output  1  registered; one-cycle pulse marking the last frame bit.

Function
REQ-010 SHALL implement FSM states IDLE, SYNC, DATA and PARITY; PARITY exists only per REQ-022.
REQ-011 SHALL accept a word on a rising edge where data_valid=1 and data_ready=1, capturing data_in into an internal shift register.
REQ-012 SHALL assert data_ready only in IDLE; data_ready=0 in every other state.
REQ-013 Frame = sync pattern 1,1,0,1, then payload MSB first, then optional parity; one bit per cycle on w.
REQ-014 Latency: if acceptance occurs at edge k, then sync bit i (i=0..3) SHALL be on w in cycle k+1+i, payload bit PAYLOAD_W-1-j in cycle k+5+j, and parity in cycle k+5+PAYLOAD_W.
REQ-015 SHALL hold busy=1 for exactly the cycles in which w carries frame bits, and busy=0 otherwise.
REQ-016 SHALL assert done=1 only in the cycle in which w carries the final frame bit.
REQ-017 After the final bit, SHALL return to IDLE with w=0 and data_ready=1 for at least one cycle, which guarantees a minimum 1-cycle zero gap between frames.
REQ-018 Back-to-back: with data_valid held high, SHALL accept the next word at the first IDLE edge, so the inter-frame gap is exactly 1 cycle.
REQ-019 SHALL ignore changes on data_in and data_valid while not in IDLE; the captured word SHALL NOT change mid-frame.
REQ-020 SHALL use a bit counter of width ceil(log2(PAYLOAD_W+1)) with no wrap-around within a frame; the DATA-to-next-state transition SHALL occur when the count reaches PAYLOAD_W-1.
REQ-021 SHALL hold w=0 in IDLE indefinitely when data_valid=0.

Configuration
REQ-022 SHALL gate the PARITY state with macro SYNC_FRAME_TX_PARITY_EN. When defined, one even-parity bit (XOR of all payload bits) follows the payload and the frame length is PAYLOAD_W+5. When undefined, no PARITY state or logic is built and the frame length is PAYLOAD_W+4.

Reset
REQ-023 When Reset=0 at a rising edge, SHALL force state=IDLE, w=0, busy=0, done=0, data_ready=0, and clear the counter and shift register.
REQ-024 Reset SHALL take priority over every other event, including acceptance in the same cycle.
REQ-025 Reset mid-frame SHALL abort the frame: w=0 from the next cycle, no done pulse, and no later resumption.
REQ-026 SHALL assert data_ready=1 from the first rising edge at which Reset=1.

Verification
REQ-027 Hold Reset=0 for 3 cycles with data_valid=1 -> w=0, busy=0, done=0 and data_ready=0 throughout, and no frame starts.
REQ-028 Without the macro, PAYLOAD_W=8, send 0xA5 -> w=1,1,0,1,1,0,1,0,0,1,0,1 in 12 consecutive cycles, done in the 12th cycle, then w=0 and data_ready=1.
REQ-029 With the macro, send 0x07 -> w=1,1,0,1,0,0,0,0,0,1,1,1,1, where the final bit is parity=1, and done in the 13th cycle.
REQ-030 With data_valid held high, send 0xFF then 0x00, toggling data_in mid-frame -> both frames are correct with exactly one w=0 gap cycle between them.
REQ-031 Assert Reset=0 for one cycle during the 3rd payload bit -> w=0 and busy=0 from the next cycle, no done pulse, and data_ready=1 one cycle after release.
REQ-032 Keep data_valid=0 for 20 cycles after reset -> w=0, busy=0 and data_ready=1 held for all 20 cycles.
